vga_fb_scanout: RTL and testbench

//  Parametrised VGA scan-out engine: generates programmable sync timing, fetches one framebuffer
//  row per output line (pre-fetched in h-blank), replicates pixels SCALE x SCALE, drives RGB.

---
 rtl/vga_pkg.sv | 45 ++++
 rtl/vga_timing_gen.sv | 43 ++++
 rtl/vga_fb_scanout.sv | 170 +++++++++++++++++
 tb/tb_vga_fb_scanout.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA definitions: default 640x480@60 timing, total/width helpers,
// RGB field positions, sync polarity encodings and the raw timing flag bundle.
package vga_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    // Channel position inside a packed {R,G,B} colour word, in units of COLOR_W.
    localparam int RGB_R_OFS = 2;
    localparam int RGB_G_OFS = 1;
    localparam int RGB_B_OFS = 0;

    typedef enum logic {
        SYNC_ACTIVE_LOW  = 1'b0,
        SYNC_ACTIVE_HIGH = 1'b1
    } sync_pol_e;

    // Raw (unregistered, active-high) timing decisions for the current counter state.
    typedef struct packed {
        logic active;
        logic hsync;
        logic vsync;
        logic frame_start;
        logic line_start;
    } timing_flags_t;

    function automatic int h_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int v_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Horizontal/vertical raster counters and the raw timing flags derived from them.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
    localparam int HCNT_W  = cnt_w(H_TOTAL),
    localparam int VCNT_W  = cnt_w(V_TOTAL)
)(
    input  logic              clk,
    input  logic              rst,
    output logic [HCNT_W-1:0] h_cnt,
    output logic [VCNT_W-1:0] v_cnt,
    output timing_flags_t     flags
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (32'(h_cnt) == H_TOTAL - 1) begin
            h_cnt <= '0;
            v_cnt <= (32'(v_cnt) == V_TOTAL - 1) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    assign flags.active      = (32'(h_cnt) < H_ACTIVE) && (32'(v_cnt) < V_ACTIVE);
    assign flags.hsync       = (32'(h_cnt) >= H_ACTIVE + H_FP) && (32'(h_cnt) < H_ACTIVE + H_FP + H_SYNC);
    assign flags.vsync       = (32'(v_cnt) >= V_ACTIVE + V_FP) && (32'(v_cnt) < V_ACTIVE + V_FP + V_SYNC);
    assign flags.frame_start = (h_cnt == '0) && (v_cnt == '0);
    assign flags.line_start  = (h_cnt == '0) && (32'(v_cnt) < V_ACTIVE);

endmodule

// File: rtl/vga_fb_scanout.sv
// VGA scan-out: raster timing, per-line framebuffer row fetch in h-blank, SCALE x SCALE
// replication and registered RGB/sync outputs. Define VGA_BORDER_EN for a fg-coloured border.
module vga_fb_scanout
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int SCALE    = 2,
    parameter int WORD_W   = 320,
    parameter int ADDR_W   = 8,
    parameter int RAM_LAT  = 1,
    parameter int COLOR_W  = 4,
    parameter int SYNC_POL = 0,
    parameter int BORDER_W = 3
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [3*COLOR_W-1:0] fg_color,
    input  logic [3*COLOR_W-1:0] bg_color,
    output logic [ADDR_W-1:0]    ram_addr,
    output logic                 ram_rd_en,
    input  logic [WORD_W-1:0]    ram_data,
    output logic                 vga_hsync,
    output logic                 vga_vsync,
    output logic [COLOR_W-1:0]   vga_r,
    output logic [COLOR_W-1:0]   vga_g,
    output logic [COLOR_W-1:0]   vga_b,
    output logic                 frame_start,
    output logic                 line_start
);

    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HCNT_W  = cnt_w(H_TOTAL);
    localparam int VCNT_W  = cnt_w(V_TOTAL);
    localparam int IDX_W   = cnt_w(WORD_W);
    localparam int SUB_W   = cnt_w(SCALE);
    localparam logic SYNC_ACT  = (SYNC_POL != 0) ? SYNC_ACTIVE_HIGH : SYNC_ACTIVE_LOW;
    localparam logic SYNC_IDLE = ~SYNC_ACT;

    if (H_TOTAL - H_ACTIVE < RAM_LAT + 2) begin : g_err_hblank
        $error("vga_fb_scanout: horizontal blanking shorter than RAM_LAT+2");
    end
    if (RAM_LAT < 1) begin : g_err_lat
        $error("vga_fb_scanout: RAM_LAT must be at least 1");
    end
    if (WORD_W * SCALE != H_ACTIVE) begin : g_err_word
        $error("vga_fb_scanout: WORD_W must equal H_ACTIVE/SCALE");
    end
    if ((2 ** ADDR_W) * SCALE < V_ACTIVE) begin : g_err_addr
        $error("vga_fb_scanout: ADDR_W too small for V_ACTIVE/SCALE rows");
    end
    if (2 * BORDER_W > H_ACTIVE || 2 * BORDER_W > V_ACTIVE) begin : g_err_border
        $error("vga_fb_scanout: BORDER_W too large for the active area");
    end

    logic [HCNT_W-1:0]  h_cnt_p0;
    logic [VCNT_W-1:0]  v_cnt_p0;
    timing_flags_t      flags_p0;
    logic [VCNT_W-1:0]  v_next_p0;
    logic               en_lat;
    logic               en_eff_p0;
    logic               fetch_p0;
    logic [RAM_LAT-1:0] rd_pipe;
    logic [WORD_W-1:0]  line_buf;
    logic [IDX_W-1:0]   idx_p0;
    logic [SUB_W-1:0]   sub_p0;
    logic               pix_p0;
    logic               border_p0;
    logic [3*COLOR_W-1:0] rgb_p0;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
    ) u_timing (
        .clk   (clk),
        .rst   (rst),
        .h_cnt (h_cnt_p0),
        .v_cnt (v_cnt_p0),
        .flags (flags_p0)
    );

    // stage p0: counter state, fetch decision, pixel lookup and colour select
    assign en_eff_p0 = flags_p0.frame_start ? enable : en_lat;
    assign v_next_p0 = (32'(v_cnt_p0) == V_TOTAL - 1) ? '0 : v_cnt_p0 + 1'b1;
    // Line 0 is fetched before the frame-start latch update, so it looks at enable directly.
    assign fetch_p0  = (32'(h_cnt_p0) == H_ACTIVE) && (32'(v_next_p0) < V_ACTIVE) &&
                       ((v_next_p0 == '0) ? enable : en_lat);
    assign pix_p0    = line_buf[idx_p0];

`ifdef VGA_BORDER_EN
    assign border_p0 = (32'(h_cnt_p0) < BORDER_W) || (32'(h_cnt_p0) >= H_ACTIVE - BORDER_W) ||
                       (32'(v_cnt_p0) < BORDER_W) || (32'(v_cnt_p0) >= V_ACTIVE - BORDER_W);
`else
    assign border_p0 = 1'b0;
`endif

    always_comb begin
        rgb_p0 = '0;
        if (flags_p0.active) begin
            if (border_p0)
                rgb_p0 = fg_color;
            else if (en_eff_p0)
                rgb_p0 = pix_p0 ? fg_color : bg_color;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_lat   <= 1'b0;
            rd_pipe  <= '0;
            line_buf <= '0;
            idx_p0   <= '0;
            sub_p0   <= '0;
        end else begin
            en_lat     <= en_eff_p0;
            rd_pipe[0] <= ram_rd_en;
            for (int i = 1; i < RAM_LAT; i++)
                rd_pipe[i] <= rd_pipe[i-1];
            if (rd_pipe[RAM_LAT-1])
                line_buf <= ram_data;
            // idx/sub describe the column the counter will show next cycle
            if (32'(h_cnt_p0) == H_TOTAL - 1) begin
                idx_p0 <= '0;
                sub_p0 <= '0;
            end else if (32'(h_cnt_p0) < H_ACTIVE - 1) begin
                if (32'(sub_p0) == SCALE - 1) begin
                    sub_p0 <= '0;
                    idx_p0 <= idx_p0 + 1'b1;
                end else begin
                    sub_p0 <= sub_p0 + 1'b1;
                end
            end
        end
    end

    // stage p1: registered, mutually aligned outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vga_hsync   <= SYNC_IDLE;
            vga_vsync   <= SYNC_IDLE;
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
            ram_rd_en   <= 1'b0;
            ram_addr    <= '0;
        end else begin
            vga_hsync   <= flags_p0.hsync ? SYNC_ACT : SYNC_IDLE;
            vga_vsync   <= flags_p0.vsync ? SYNC_ACT : SYNC_IDLE;
            vga_r       <= rgb_p0[RGB_R_OFS*COLOR_W +: COLOR_W];
            vga_g       <= rgb_p0[RGB_G_OFS*COLOR_W +: COLOR_W];
            vga_b       <= rgb_p0[RGB_B_OFS*COLOR_W +: COLOR_W];
            frame_start <= flags_p0.frame_start;
            line_start  <= flags_p0.line_start;
            ram_rd_en   <= fetch_p0;
            if (fetch_p0)
                ram_addr <= ADDR_W'(32'(v_next_p0) / SCALE);
        end
    end

endmodule

// File: tb/tb_vga_fb_scanout.sv
// Self-checking bench for vga_fb_scanout on a reduced raster (24x17 clocks per frame grid).
`timescale 1ns/1ps
module tb_vga_fb_scanout;

    localparam int HA = 16, HFP = 2, HS = 3, HBP = 3;
    localparam int VA = 12, VFP = 1, VS = 2, VBP = 2;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int FT = HT * VT;
    localparam int SC = 2;
    localparam int BW = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b1;
    logic [11:0] fg_color = 12'hFFF;
    logic [11:0] bg_color = 12'h000;
    logic [2:0]  ram_addr;
    logic        ram_rd_en;
    logic [7:0]  ram_data = 8'h00;
    logic        vga_hsync, vga_vsync;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        frame_start, line_start;

    logic [7:0]  mem [0:7];
    int          checks = 0;
    int          failures = 0;
    int          cur = 0;

    vga_fb_scanout #(
        .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
        .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP),
        .SCALE (SC), .WORD_W (8), .ADDR_W (3), .RAM_LAT (1),
        .COLOR_W (4), .SYNC_POL (0), .BORDER_W (BW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .fg_color    (fg_color),
        .bg_color    (bg_color),
        .ram_addr    (ram_addr),
        .ram_rd_en   (ram_rd_en),
        .ram_data    (ram_data),
        .vga_hsync   (vga_hsync),
        .vga_vsync   (vga_vsync),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .frame_start (frame_start),
        .line_start  (line_start)
    );

    always #5 clk = ~clk;

    // One-cycle-latency RAM; junk on idle cycles exposes a mis-timed capture.
    always @(posedge clk) ram_data <= ram_rd_en ? mem[ram_addr] : 8'h5A;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: outputs after edge e reflect raster position s=e-1 since reset release.
    int          e = 0;
    logic        en_frame = 1'b0, en_prev = 1'b0;
    logic [11:0] fg_prev = '0, bg_prev = '0;

    always @(negedge clk) begin
        int s, h, v, vn;
        logic active, border, pix, exp_hs, exp_vs, exp_rd;
        logic [11:0] exp_rgb;
        if (rst) begin
            e = 0;
            chk("reset_outputs",
                {vga_hsync, vga_vsync, frame_start, line_start, ram_rd_en, ram_addr, vga_r, vga_g, vga_b},
                32'h000C0000);
        end else begin
            e = e + 1;
            s = e - 1;
            h = s % HT;
            v = (s / HT) % VT;
            if (h == 0 && v == 0) en_frame = en_prev;
            active = (h < HA) && (v < VA);
            exp_hs = !((h >= HA + HFP) && (h < HA + HFP + HS));
            exp_vs = !((v >= VA + VFP) && (v < VA + VFP + VS));
            vn     = (v + 1) % VT;
            exp_rd = (h == HA) && (vn < VA) && ((vn == 0) ? en_prev : en_frame);
            pix    = 1'b0;
            if (active && !((s / FT) == 0 && v == 0)) pix = mem[v / SC][h / SC];
`ifdef VGA_BORDER_EN
            border = (h < BW) || (h >= HA - BW) || (v < BW) || (v >= VA - BW);
`else
            border = 1'b0;
`endif
            exp_rgb = 12'h000;
            if (active) begin
                if (border) exp_rgb = fg_prev;
                else if (en_frame) exp_rgb = pix ? fg_prev : bg_prev;
            end
            chk("syncs", {vga_hsync, vga_vsync}, {exp_hs, exp_vs});
            chk("pulses", {frame_start, line_start}, {(h == 0 && v == 0), (h == 0 && v < VA)});
            chk("rgb", {vga_r, vga_g, vga_b}, exp_rgb);
            chk("rd_en", ram_rd_en, exp_rd);
            if (exp_rd) chk("ram_addr", ram_addr, vn / SC);
        end
        en_prev = enable;
        fg_prev = fg_color;
        bg_prev = bg_color;
    end

    // Advance to just after the n-th rising edge since the last reset release.
    task automatic goto(input int n);
        while (cur < n) begin
            @(posedge clk);
            cur++;
        end
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        #2;
        rst = 1'b0;
        cur = 0;
    endtask

    initial begin
        logic [11:0] b_col2, b_col13;
`ifdef VGA_BORDER_EN
        b_col2 = 12'hFFF; b_col13 = 12'hFFF;
`else
        b_col2 = 12'h000; b_col13 = 12'h000;
`endif
        mem[0] = 8'h01; mem[1] = 8'hF0; mem[2] = 8'hA5; mem[3] = 8'h3C;
        mem[4] = 8'hFF; mem[5] = 8'h00; mem[6] = 8'hDE; mem[7] = 8'hAD;
        repeat (3) @(posedge clk);
        release_reset();

        goto(1);   chk("first_frame_start", {frame_start, line_start}, 2'b11);
                   chk("first_syncs_idle", {vga_hsync, vga_vsync}, 2'b11);
        goto(2);   chk("frame_start_1cyc", {frame_start, line_start}, 2'b00);
        goto(16);  chk("no_fetch_h15", ram_rd_en, 1'b0);
        goto(17);  chk("fetch_v0_for_line1", {ram_rd_en, ram_addr}, {1'b1, 3'd0});
        goto(18);  chk("fetch_single_pulse", ram_rd_en, 1'b0);
                   chk("hsync_before", vga_hsync, 1'b1);
        goto(19);  chk("hsync_first_low", vga_hsync, 1'b0);
        goto(21);  chk("hsync_last_low", vga_hsync, 1'b0);
        goto(22);  chk("hsync_after", vga_hsync, 1'b1);
        goto(25);  chk("line_start_v1", {frame_start, line_start}, 2'b01);
        goto(257); chk("fetch_row5", {ram_rd_en, ram_addr}, {1'b1, 3'd5});
        goto(281); chk("no_fetch_past_active", ram_rd_en, 1'b0);
        goto(312); chk("vsync_before", vga_vsync, 1'b1);
        goto(313); chk("vsync_first_low", vga_vsync, 1'b0);
        goto(360); chk("vsync_last_low", vga_vsync, 1'b0);
        goto(361); chk("vsync_after", vga_vsync, 1'b1);
        goto(401); chk("fetch_line0_next_frame", {ram_rd_en, ram_addr}, {1'b1, 3'd0});
        goto(409); chk("frame_period", frame_start, 1'b1);
                   chk("col0_fg", {vga_r, vga_g, vga_b}, 12'hFFF);
        goto(410); chk("col1_fg", {vga_r, vga_g, vga_b}, 12'hFFF);
        goto(411); chk("col2", {vga_r, vga_g, vga_b}, b_col2);
        goto(484); chk("pix_3_3_bg", {vga_r, vga_g, vga_b}, 12'h000);
        goto(518); chk("pix_13_4", {vga_r, vga_g, vga_b}, b_col13);

        goto(900); #1;
        fg_color = 12'h0F0;
        bg_color = 12'h5A3;
        goto(1375); #1;
        enable = 1'b0;
        goto(1481); chk("drop_frame_keeps_fetching", {ram_rd_en, ram_addr}, {1'b1, 3'd5});
        goto(1625); chk("no_line0_fetch_disabled", ram_rd_en, 1'b0);
        goto(1649); chk("disabled_no_fetch", ram_rd_en, 1'b0);
        goto(1758); chk("disabled_active_black", {vga_r, vga_g, vga_b}, 12'h000);
        goto(1783); #1;
        enable = 1'b1;
        goto(2033); chk("reenable_line0_fetch", {ram_rd_en, ram_addr}, {1'b1, 3'd0});
        goto(2116); chk("reenabled_bg", {vga_r, vga_g, vga_b}, 12'h5A3);
        goto(2121); chk("reenabled_fg", {vga_r, vga_g, vga_b}, 12'h0F0);

        goto(2579); #1;
        rst = 1'b1;
        #1;
        chk("async_reset_now",
            {vga_hsync, vga_vsync, frame_start, line_start, ram_rd_en, ram_addr, vga_r, vga_g, vga_b},
            32'h000C0000);
        repeat (3) @(posedge clk);
        release_reset();
        goto(1);   chk("restart_frame_start", frame_start, 1'b1);
        goto(19);  chk("restart_hsync_low", vga_hsync, 1'b0);
        goto(22);  chk("restart_hsync_high", vga_hsync, 1'b1);
        goto(409); chk("restart_frame_period", frame_start, 1'b1);
        goto(600);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
